// File: rtl/prefetch_buffer.sv
// Instruction prefetch buffer: pipelined word fetches over req/gnt/rvalid with
// a DEPTH-entry {addr, data} FIFO drained by the IF stage; branches flush it.
module prefetch_buffer #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  input  logic        ready_i,
  output logic        busy_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] C_ZERO = CW'(0);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [OW-1:0] O_ZERO = OW'(0);
  localparam logic [OW-1:0] O_ONE  = OW'(1);
  localparam logic [PW-1:0] P_ZERO = PW'(0);
  localparam logic [PW-1:0] P_ONE  = PW'(1);
  localparam logic [31:0]   DEPTH_W = 32'(DEPTH);
  localparam logic [31:0]   MAX_W   = 32'(MAX_OUTSTANDING);

  logic          r_req, r_stale, r_started, r_valid, r_busy;
  logic [31:0]   r_iaddr, r_next, r_resp_addr, r_rdata, r_haddr;
  logic [OW-1:0] r_out, r_disc;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wptr, r_rptr;
  logic [31:0]   r_mem_data [DEPTH];
  logic [31:0]   r_mem_addr [DEPTH];

  logic          w_gnt, w_rv, w_pop, w_push, w_hold, w_launch, w_started_n;
  logic [31:0]   w_target, w_next_base, w_fill;
  logic [OW-1:0] w_out_n, w_disc_n;
  logic [CW-1:0] w_count_n, w_cnt_pop;
  logic [PW-1:0] w_rptr_n;

  // Next-state bookkeeping; each outstanding request reserves one FIFO slot
  always_comb begin
    w_target    = branch_addr_i & 32'hFFFF_FFFC;
    w_gnt       = r_req & instr_gnt_i;
    w_rv        = instr_rvalid_i & (r_out != O_ZERO);
    w_pop       = r_valid & ready_i;
    w_push      = w_rv & (r_disc == O_ZERO) & ~branch_i;
    w_hold      = r_req & ~instr_gnt_i;
    w_started_n = r_started | branch_i;
    w_next_base = branch_i ? w_target : r_next;
    w_out_n     = r_out + (w_gnt ? O_ONE : O_ZERO) - (w_rv ? O_ONE : O_ZERO);
    w_cnt_pop   = r_count - (w_pop ? C_ONE : C_ZERO);
    w_rptr_n    = r_rptr + (w_pop ? P_ONE : P_ZERO);
    if (branch_i) begin
      w_count_n = C_ZERO;
      w_disc_n  = w_out_n;
    end else begin
      w_count_n = w_cnt_pop + (w_push ? C_ONE : C_ZERO);
      w_disc_n  = r_disc - ((w_rv && (r_disc != O_ZERO)) ? O_ONE : O_ZERO)
                         + ((w_gnt && r_stale) ? O_ONE : O_ZERO);
    end
    w_fill   = 32'(w_count_n) + 32'(w_out_n);
    w_launch = ~w_hold & w_started_n & req_i & (32'(w_out_n) < MAX_W) & (w_fill < DEPTH_W);
  end

  // Request channel: a request stays frozen until granted, even across a branch
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_req     <= 1'b0;
      r_iaddr   <= 32'h0;
      r_next    <= 32'h0;
      r_stale   <= 1'b0;
      r_started <= 1'b0;
      r_out     <= O_ZERO;
      r_disc    <= O_ZERO;
      r_busy    <= 1'b0;
    end else begin
      r_started <= w_started_n;
      r_out     <= w_out_n;
      r_disc    <= w_disc_n;
      r_busy    <= (w_out_n != O_ZERO);
      r_stale   <= w_hold & (r_stale | branch_i);
      if (w_hold) begin
        r_next <= w_next_base;
      end else if (w_launch) begin
        r_req   <= 1'b1;
        r_iaddr <= w_next_base;
        r_next  <= w_next_base + 32'd4;
      end else begin
        r_req  <= 1'b0;
        r_next <= w_next_base;
      end
    end
  end

  // FIFO pointers, response address and registered head
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count     <= C_ZERO;
      r_wptr      <= P_ZERO;
      r_rptr      <= P_ZERO;
      r_resp_addr <= 32'h0;
      r_valid     <= 1'b0;
      r_rdata     <= 32'h0;
      r_haddr     <= 32'h0;
    end else begin
      r_count <= w_count_n;
      r_valid <= (w_count_n != C_ZERO);
      if (branch_i) begin
        r_rptr      <= r_wptr;
        r_resp_addr <= w_target;
      end else begin
        r_rptr <= w_rptr_n;
        if (w_push) begin
          r_wptr      <= r_wptr + P_ONE;
          r_resp_addr <= r_resp_addr + 32'd4;
        end
        if (w_cnt_pop != C_ZERO) begin
          r_rdata <= r_mem_data[w_rptr_n];
          r_haddr <= r_mem_addr[w_rptr_n];
        end else if (w_push) begin
          r_rdata <= instr_rdata_i;
          r_haddr <= r_resp_addr;
        end
      end
    end
  end

  // Storage array; only read after it has been written, so it needs no reset
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_data[r_wptr] <= instr_rdata_i;
      r_mem_addr[r_wptr] <= r_resp_addr;
    end
  end

  assign instr_req_o  = r_req;
  assign instr_addr_o = r_iaddr;
  assign valid_o      = r_valid;
  assign rdata_o      = r_rdata;
  assign addr_o       = r_haddr;
  assign busy_o       = r_busy;

endmodule

// File: tb/tb_prefetch_buffer.sv
// Self-checking bench for prefetch_buffer: vector table, directed corner
// sequences and randomized traffic against a transaction-level model.
module tb_prefetch_buffer;

  logic        clk, rst_ni, req_i, branch_i, instr_gnt_i, instr_rvalid_i, ready_i;
  logic [31:0] branch_addr_i, instr_rdata_i;
  logic        instr_req_o, valid_o, busy_o;
  logic [31:0] instr_addr_o, rdata_o, addr_o;

  prefetch_buffer #(.DEPTH(4), .MAX_OUTSTANDING(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .branch_i(branch_i),
    .branch_addr_i(branch_addr_i), .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i),
    .instr_addr_o(instr_addr_o), .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .valid_o(valid_o), .rdata_o(rdata_o), .addr_o(addr_o), .ready_i(ready_i), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // memory / traffic controls
  bit model_on = 1'b1, mem_auto = 1'b0, gnt_auto = 1'b0;
  int gnt_pct = 100, rv_pct = 100;
  logic [31:0] mq[$];
  logic [31:0] g_q[$];
  logic [31:0] p_q[$];
  int n_grant;

  // per-cycle samples
  logic        s_req, s_gnt, s_rv, s_valid, s_rdy, s_br, s_busy;
  logic [31:0] s_addr, s_haddr, s_hdata, s_ba;

  // reference model state
  int          m_out;
  bit          m_started, m_pend, m_prev_hold, m_prev_branch;
  logic [31:0] m_fetch, m_pend_target, m_exp, m_prev_addr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit rv_eff;
    if (m_prev_hold) begin
      chk("req_held", 32'(s_req), 32'd1);
      chk("addr_held", s_addr, m_prev_addr);
    end
    if (!m_started) chk("no_req_before_branch", 32'(s_req), 32'd0);
    chk("busy", 32'(s_busy), 32'(m_out != 0));
    if (m_prev_branch) chk("valid_after_branch", 32'(s_valid), 32'd0);
    if (s_valid && s_rdy) begin
      chk("pop_addr", s_haddr, m_exp);
      chk("pop_data", s_hdata, memf(m_exp));
      m_exp = m_exp + 32'd4;
    end
    rv_eff = s_rv && (m_out != 0);
    if (s_req && s_gnt) begin
      chk("grant_addr", s_addr, m_fetch);
      if (m_pend) begin
        m_fetch = m_pend_target;
        m_pend  = 1'b0;
      end else begin
        m_fetch = m_fetch + 32'd4;
      end
      m_out++;
    end
    if (rv_eff) m_out--;
    chk("outstanding_max", 32'(m_out <= 2), 32'd1);
    if (s_br) begin
      m_exp = s_ba;
      if (s_req && !s_gnt) begin
        m_pend = 1'b1;
        m_pend_target = s_ba;
      end else begin
        m_fetch = s_ba;
        m_pend  = 1'b0;
      end
      m_started = 1'b1;
    end
    m_prev_hold   = s_req && !s_gnt;
    m_prev_addr   = s_addr;
    m_prev_branch = s_br;
  endtask

  // one clock: sample at negedge, update model/memory, drive at posedge+1
  task automatic tick();
    @(negedge clk);
    s_req = instr_req_o; s_addr = instr_addr_o; s_gnt = instr_gnt_i; s_rv = instr_rvalid_i;
    s_valid = valid_o; s_rdy = ready_i; s_haddr = addr_o; s_hdata = rdata_o;
    s_br = branch_i; s_ba = branch_addr_i & 32'hFFFF_FFFC; s_busy = busy_o;
    if (model_on) model_step();
    if (s_req && s_gnt) begin
      n_grant++;
      g_q.push_back(s_addr);
      if (mem_auto) mq.push_back(s_addr);
    end
    if (s_valid && s_rdy) p_q.push_back(s_haddr);
    @(posedge clk);
    #1;
    branch_i = 1'b0;
    if (gnt_auto) instr_gnt_i = ($urandom_range(0, 99) < gnt_pct);
    if (mem_auto) begin
      if (mq.size() > 0 && $urandom_range(0, 99) < rv_pct) begin
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = memf(mq.pop_front());
      end else begin
        instr_rvalid_i = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    req_i = 1'b0; branch_i = 1'b0; branch_addr_i = 32'h0; instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b0; instr_rdata_i = 32'h0; ready_i = 1'b0;
    #2;
    chk("reset_req", 32'(instr_req_o), 32'd0);
    chk("reset_addr", instr_addr_o, 32'h0);
    chk("reset_valid", 32'(valid_o), 32'd0);
    chk("reset_rdata", rdata_o, 32'h0);
    chk("reset_addr_o", addr_o, 32'h0);
    chk("reset_busy", 32'(busy_o), 32'd0);
    m_out = 0; m_started = 1'b0; m_pend = 1'b0; m_prev_hold = 1'b0; m_prev_branch = 1'b0;
    m_fetch = 32'h0; m_exp = 32'h0;
    mq.delete(); g_q.delete(); p_q.delete(); n_grant = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!valid_o && k < 30) begin
      tick();
      k++;
    end
    chk({name, "_valid_timeout"}, 32'(valid_o), 32'd1);
  endtask

  typedef struct {
    logic br; logic [31:0] ba; logic rq; logic gnt; logic rv; logic [31:0] rd; logic rdy;
    logic e_req; logic [31:0] e_addr; logic e_valid; logic [31:0] e_haddr; logic [31:0] e_hdata;
  } vec_t;

  vec_t vt[9];

  initial begin
    rst_ni = 1'b0;
    do_reset();

    // streaming from 0x80: zero-wait grant, rvalid one cycle after grant
    vt[0] = '{1'b1, 32'h80, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0};
    vt[1] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h80, 1'b0, 32'h0,  32'h0};
    vt[2] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, memf(32'h80), 1'b1, 1'b1, 32'h84, 1'b0, 32'h0,  32'h0};
    vt[3] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, memf(32'h84), 1'b1, 1'b1, 32'h88, 1'b1, 32'h80, memf(32'h80)};
    vt[4] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, memf(32'h88), 1'b1, 1'b1, 32'h8C, 1'b1, 32'h84, memf(32'h84)};
    vt[5] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, memf(32'h8C), 1'b1, 1'b1, 32'h90, 1'b1, 32'h88, memf(32'h88)};
    vt[6] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, memf(32'h90), 1'b1, 1'b0, 32'h0,  1'b1, 32'h8C, memf(32'h8C)};
    vt[7] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,  1'b1, 32'h90, memf(32'h90)};
    vt[8] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0};
    for (int i = 0; i < 9; i++) begin
      branch_i = vt[i].br; branch_addr_i = vt[i].ba; req_i = vt[i].rq; instr_gnt_i = vt[i].gnt;
      instr_rvalid_i = vt[i].rv; instr_rdata_i = vt[i].rd; ready_i = vt[i].rdy;
      tick();
      chk($sformatf("vec%0d_req", i), 32'(s_req), 32'(vt[i].e_req));
      if (vt[i].e_req) chk($sformatf("vec%0d_addr", i), s_addr, vt[i].e_addr);
      chk($sformatf("vec%0d_valid", i), 32'(s_valid), 32'(vt[i].e_valid));
      if (vt[i].e_valid) begin
        chk($sformatf("vec%0d_head_addr", i), s_haddr, vt[i].e_haddr);
        chk($sformatf("vec%0d_head_data", i), s_hdata, vt[i].e_hdata);
      end
    end

    // capacity: ready low fills FIFO with exactly DEPTH grants; one pop frees one slot
    do_reset();
    mem_auto = 1'b1; gnt_auto = 1'b1; gnt_pct = 100; rv_pct = 100;
    instr_gnt_i = 1'b1; req_i = 1'b1; ready_i = 1'b0;
    branch_i = 1'b1; branch_addr_i = 32'h100;
    tick();
    repeat (12) tick();
    chk("fill_grants", 32'(n_grant), 32'd4);
    chk("fill_req_dropped", 32'(instr_req_o), 32'd0);
    chk("fill_head", addr_o, 32'h100);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    repeat (8) tick();
    chk("refill_grants", 32'(n_grant), 32'd5);
    chk("refill_req_dropped", 32'(instr_req_o), 32'd0);

    // branch with two responses in flight: both dropped
    do_reset();
    rv_pct = 0; instr_gnt_i = 1'b1; req_i = 1'b1; ready_i = 1'b1;
    branch_i = 1'b1; branch_addr_i = 32'h10;
    repeat (3) tick();
    chk("inflight_busy", 32'(busy_o), 32'd1);
    chk("inflight_req_stalled", 32'(instr_req_o), 32'd0);
    branch_i = 1'b1; branch_addr_i = 32'h200; rv_pct = 100;
    tick();
    wait_valid("discard");
    chk("discard_head_addr", addr_o, 32'h200);
    chk("discard_head_data", rdata_o, memf(32'h200));
    repeat (4) tick();

    // branch while an ungranted request is pending
    do_reset();
    gnt_auto = 1'b0; instr_gnt_i = 1'b0; req_i = 1'b1; ready_i = 1'b1;
    branch_i = 1'b1; branch_addr_i = 32'h40;
    tick();
    chk("pend_req", 32'(instr_req_o), 32'd1);
    chk("pend_addr0", instr_addr_o, 32'h40);
    branch_i = 1'b1; branch_addr_i = 32'h300;
    tick();
    chk("pend_addr1", instr_addr_o, 32'h40);
    tick();
    chk("pend_addr2", instr_addr_o, 32'h40);
    instr_gnt_i = 1'b1;
    tick();
    chk("pend_new_req", 32'(instr_req_o), 32'd1);
    chk("pend_new_addr", instr_addr_o, 32'h300);
    gnt_auto = 1'b1;
    wait_valid("pend");
    chk("pend_head_addr", addr_o, 32'h300);
    chk("pend_head_data", rdata_o, memf(32'h300));
    repeat (4) tick();

    // address wrap at the top of memory
    do_reset();
    instr_gnt_i = 1'b1; req_i = 1'b1; ready_i = 1'b1;
    branch_i = 1'b1; branch_addr_i = 32'hFFFF_FFF8;
    repeat (9) tick();
    chk("wrap_counts", 32'(g_q.size() >= 3 && p_q.size() >= 3), 32'd1);
    if (g_q.size() >= 3 && p_q.size() >= 3) begin
      chk("wrap_g0", g_q[0], 32'hFFFF_FFF8);
      chk("wrap_g1", g_q[1], 32'hFFFF_FFFC);
      chk("wrap_g2", g_q[2], 32'h0000_0000);
      chk("wrap_p2", p_q[2], 32'h0000_0000);
    end

    // asynchronous reset with FIFO half full and one request outstanding
    do_reset();
    instr_gnt_i = 1'b1; req_i = 1'b1; ready_i = 1'b0;
    branch_i = 1'b1; branch_addr_i = 32'h500;
    repeat (3) tick();
    req_i = 1'b0; rv_pct = 0;
    tick();
    chk("prerst_valid", 32'(valid_o), 32'd1);
    chk("prerst_busy", 32'(busy_o), 32'd1);
    do_reset();
    mem_auto = 1'b0; gnt_auto = 1'b0;
    instr_rvalid_i = 1'b1; instr_rdata_i = 32'hDEAD_BEEF;
    tick();
    instr_rvalid_i = 1'b0;
    repeat (2) tick();
    chk("late_rvalid_valid", 32'(valid_o), 32'd0);
    chk("late_rvalid_busy", 32'(busy_o), 32'd0);

    // randomized traffic against the model
    do_reset();
    mem_auto = 1'b1; gnt_auto = 1'b1; gnt_pct = 70; rv_pct = 60;
    req_i = 1'b1; branch_i = 1'b1; branch_addr_i = $urandom;
    tick();
    for (int c = 0; c < 3000; c++) begin
      req_i   = ($urandom_range(0, 9) != 0);
      ready_i = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 29) == 0) begin
        branch_i = 1'b1;
        if ($urandom_range(0, 3) == 0) branch_addr_i = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
        else branch_addr_i = $urandom;
      end
      tick();
    end
    chk("random_pops", 32'(p_q.size() > 100), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/prefetch_buffer.md
# prefetch_buffer

Parametrised instruction prefetch buffer between the instruction memory port and the IF stage. It issues word-aligned fetches over the req/gnt/rvalid protocol with up to MAX_OUTSTANDING transactions in flight. Returned words are queued with their addresses in a DEPTH-entry FIFO, which the IF stage drains through a valid/ready handshake. A branch redirect flushes the FIFO and discards in-flight responses. The single-request, single-cycle fetch path gains pipelined, stall-tolerant fetching.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- MAX_OUTSTANDING, 2, max granted-but-unanswered requests; 1..DEPTH
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, asynchronous active-low reset
- req_i  in  1  fetch enable; 0 stops new requests
- branch_i  in  1  redirect strobe
- branch_addr_i  in  32  redirect target; bits [1:0] forced to 0
- instr_req_o  out  1  memory request
- instr_gnt_i  in  1  request accepted
- instr_addr_o  out  32  request address, word-aligned
- instr_rvalid_i  in  1  response valid
- instr_rdata_i  in  32  response data
- valid_o  out  1  FIFO head valid
- rdata_o  out  32  head instruction
- addr_o  out  32  head instruction address
- ready_i  in  1  IF stage consumes head
- busy_o  out  1  outstanding count ≠ 0

## Operation
- Reset values: instr_req_o=0, instr_addr_o=0, valid_o=0, rdata_o=0, addr_o=0, busy_o=0, all counters 0, block idle.
- No requests are issued until the first branch_i after reset. The core redirects to boot_addr_i to start fetching.
- Request condition:
  - req_i=1
  - outstanding < MAX_OUTSTANDING
  - fifo_count + outstanding < DEPTH (space reserved per request, so the FIFO never overflows)
  - not inside the branch cycle
- Once instr_req_o=1, instr_req_o and instr_addr_o stay stable until instr_gnt_i, regardless of req_i or branch_i.
- On req&gnt: outstanding+1, fetch address +4. Wrap is 0xFFFF_FFFC→0x0000_0000.
- On instr_rvalid_i:
  - outstanding−1.
  - If discard>0: word dropped, discard−1.
  - Else: push {resp_addr, instr_rdata_i}, resp_addr+4.
- rvalid with outstanding=0 is ignored, with no state change.
- Branch at cycle t:
  - FIFO emptied.
  - discard = outstanding after cycle t's gnt/rvalid updates, counting a granted-but-pending request.
  - Fetch and resp_addr set to branch_addr_i.
- An ungranted request pending at the branch is kept until granted, counted as discard, then the new address is issued.
- Pop when valid_o & ready_i. Push and pop in the same cycle leave count unchanged.
- branch_i together with a pop: the pop counts as accepted, then the flush applies.
- branch_i together with a push: the branch wins and the word is dropped.
- Counter widths: $clog2(DEPTH+1) and $clog2(MAX_OUTSTANDING+1). The FIFO uses circular pointers of $clog2(DEPTH) bits.
- req_i=0: in-flight responses still complete and are queued. A stable pending request is still held.

## Timing
- Branch at t, no pending ungranted request: instr_req_o=1 with instr_addr_o=branch target at t+1.
- Back-to-back requests: one per cycle while the grant and space conditions hold.
- rvalid at cycle r: valid_o=1 and head updated at r+1. There is no combinational bypass.
- Pop at p: next entry is presented at p+1, or valid_o=0 if the FIFO is now empty.
- Branch at t: valid_o=0 at t+1.
- busy_o and valid_o are registered. instr_req_o and instr_addr_o come from registered state.
- rst_ni low mid-operation: all state and outputs return to reset values asynchronously. Memory-side responses after reset are ignored.

## Test plan
- Reset, branch to 0x0000_0080, memory with zero-wait grant and 1-cycle rvalid, ready_i=1 → addresses 0x80, 0x84, 0x88 issued on consecutive cycles; valid_o carries (0x80, mem[0x80]) in order, one per cycle.
- ready_i=0, DEPTH=4, MAX_OUTSTANDING=2 → exactly 4 grants, instr_req_o drops. After one pop, exactly one new request is issued. The FIFO never overflows.
- Branch to 0x200 while 2 requests are outstanding → both responses dropped. The first valid_o word has addr_o=0x200 and data mem[0x200].
- Branch while instr_req_o=1 at 0x40 with gnt held low 3 cycles → addr stays 0x40 until grant. That response is discarded, and the next request address is the branch target.
- Fetch from 0xFFFF_FFF8 → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. addr_o matches each word.
- Assert rst_ni=0 with FIFO half-full and 1 outstanding → all outputs 0 immediately. A late rvalid after reset causes no push; valid_o stays 0.
